// File: rtl/gearbox_pkg.sv
// Shared constants and block type for the 66b->32b TX gearbox.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the gearbox paces its source through block_req/pause.
package gearbox_pkg;

  localparam int SEQ_LEN  = 33;               // cycles per gearbox period
  localparam int SEQ_MAX  = SEQ_LEN - 1;      // last sequence value (idle cycle)
  localparam int BLOCK_W  = 66;               // sync header + payload
  localparam int OUT_W    = 32;               // transceiver word width
  localparam int BUF_W    = 128;              // bit accumulator width
  localparam int MAX_FILL = OUT_W + BLOCK_W - 2;  // peak occupancy: 30 residual + 66 new
  localparam int SEQ_W    = 6;
  localparam int CNT_W    = 7;

  localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'(SEQ_MAX);

  // Header sits in the low bits so it is shifted out ahead of the payload.
  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  h;
  } block66_t;

  typedef logic [BUF_W-1:0] acc_t;

  // Zero-extend a block to accumulator width and place it above the residual bits.
  function automatic acc_t place_block(input block66_t blk, input logic [CNT_W-1:0] cnt);
    acc_t ext;
    ext = {{(BUF_W-BLOCK_W){1'b0}}, blk};
    return ext << cnt;
  endfunction

endpackage

// File: rtl/gb_seq_counter.sv
// Gearbox sequence counter: counts 0..32 while enabled, decodes block request and pause.
// Latency: block_req combinational from seq; pause_next is one cycle ahead of the pause cycle.
// Backpressure: none accepted; enable low holds the count at 0.
module gb_seq_counter
  import gearbox_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic [SEQ_W-1:0] seq,
  output logic             block_req,
  output logic             pause_next
);

  // Period counter: restarts at 0 whenever the gearbox is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq <= '0;
    end else if (!enable) begin
      seq <= '0;
    end else if (seq == SEQ_LAST) begin
      seq <= '0;
    end else begin
      seq <= seq + SEQ_W'(1);
    end
  end

  // One block every even cycle except the idle cycle at the end of the period.
  assign block_req  = enable && (seq < SEQ_LAST) && !seq[0];
  // Next cycle is the idle cycle; the top registers this into the pause output.
  assign pause_next = enable && (seq == SEQ_LAST - SEQ_W'(1));

endmodule

// File: rtl/tx_gearbox_6632.sv
// TX gearbox packing 66-bit blocks into 32-bit words; optional checker under TX_GEARBOX_CHECK_EN.
// Latency: header bit 0 of the block sampled at seq N reaches o_gb_data[0] at N+1.
// Backpressure: encoder is paced by o_block_req and held on the idle cycle by o_tx_pause.
module tx_gearbox_6632
  import gearbox_pkg::*;
(
  input  logic             i_txc,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic [63:0]      i_txd,
  input  logic [1:0]       i_tx_header,
  output logic             o_block_req,
  output logic             o_tx_pause,
  output logic [OUT_W-1:0] o_gb_data,
  output logic [SEQ_W-1:0] o_gb_seq
`ifdef TX_GEARBOX_CHECK_EN
  ,
  output logic             o_gb_err
`endif
);

  logic [SEQ_W-1:0] seq;
  logic             block_req;
  logic             pause_next;

  block66_t         blk;
  acc_t             acc_q;
  acc_t             acc_ld;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_ld;
  logic [CNT_W-1:0] cnt_next;

  gb_seq_counter u_seq (
    .clk        (i_txc),
    .rst_n      (i_reset_n),
    .enable     (i_enable),
    .seq        (seq),
    .block_req  (block_req),
    .pause_next (pause_next)
  );

  assign blk         = {i_txd, i_tx_header};
  assign o_block_req = block_req;
  assign o_gb_seq    = seq;

  // Merge the requested block above the residual bits, then account for one word out.
  always_comb begin
    acc_ld = acc_q;
    cnt_ld = cnt_q;
    if (block_req) begin
      acc_ld = acc_q | place_block(blk, cnt_q);
      cnt_ld = cnt_q + CNT_W'(BLOCK_W);
    end
    cnt_next = cnt_ld - CNT_W'(OUT_W);
  end

  // Emit the low word each enabled cycle; disabling discards any partial block.
  always_ff @(posedge i_txc or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      o_gb_data  <= '0;
      o_tx_pause <= 1'b0;
    end else if (!i_enable) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      o_gb_data  <= '0;
      o_tx_pause <= 1'b0;
    end else begin
      o_gb_data  <= acc_ld[OUT_W-1:0];
      acc_q      <= acc_ld >> OUT_W;
      cnt_q      <= cnt_next;
      o_tx_pause <= pause_next;
    end
  end

`ifdef TX_GEARBOX_CHECK_EN
  // Sticky fill error: overfill, underflow, or residue left over when the period wraps.
  always_ff @(posedge i_txc or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_gb_err <= 1'b0;
    end else if (!i_enable) begin
      o_gb_err <= 1'b0;
    end else if ((cnt_ld > CNT_W'(MAX_FILL)) ||
                 (cnt_ld < CNT_W'(OUT_W)) ||
                 ((seq == SEQ_LAST) && (cnt_next != '0))) begin
      o_gb_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tx_gearbox_6632.sv
// Directed bench for tx_gearbox_6632: reset, cadence, bit order, period integrity, reset and enable drop.
// Latency: inputs driven at the falling edge, outputs sampled 1 ns later.
// Backpressure: n/a.
module tb_tx_gearbox_6632;

  logic        i_txc = 1'b0;
  logic        i_reset_n;
  logic        i_enable;
  logic [63:0] i_txd;
  logic [1:0]  i_tx_header;
  logic        o_block_req;
  logic        o_tx_pause;
  logic [31:0] o_gb_data;
  logic [5:0]  o_gb_seq;
`ifdef TX_GEARBOX_CHECK_EN
  logic        o_gb_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 i_txc = ~i_txc;

  tx_gearbox_6632 dut (
    .i_txc       (i_txc),
    .i_reset_n   (i_reset_n),
    .i_enable    (i_enable),
    .i_txd       (i_txd),
    .i_tx_header (i_tx_header),
    .o_block_req (o_block_req),
    .o_tx_pause  (o_tx_pause),
    .o_gb_data   (o_gb_data),
    .o_gb_seq    (o_gb_seq)
`ifdef TX_GEARBOX_CHECK_EN
    ,
    .o_gb_err    (o_gb_err)
`endif
  );

  task automatic tick;
    @(negedge i_txc);
  endtask

  task automatic flush;
    i_enable = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    i_reset_n   = 1'b0;
    i_enable    = 1'b0;
    i_txd       = '0;
    i_tx_header = '0;
    repeat (3) tick();
    #1;
    checks++; if (o_gb_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", o_gb_data); end
    checks++; if (o_tx_pause !== 1'b0) begin errors++; $display("FAIL reset_pause: got %b expected 0", o_tx_pause); end
    checks++; if (o_gb_seq !== 6'd0) begin errors++; $display("FAIL reset_seq: got %0d expected 0", o_gb_seq); end
`ifdef TX_GEARBOX_CHECK_EN
    checks++; if (o_gb_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", o_gb_err); end
`endif
    tick();
    i_reset_n   = 1'b1;
    i_enable    = 1'b1;
    i_txd       = '1;
    i_tx_header = 2'b11;
    repeat (3) tick();
    #1;
    checks++; if (o_gb_seq !== 6'd3) begin errors++; $display("FAIL async_pre_seq: got %0d expected 3", o_gb_seq); end
    checks++; if (o_gb_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL async_pre_data: got %h expected ffffffff", o_gb_data); end
    // Reset asserted 2 ns after a rising edge; outputs must clear well before the next one.
    @(posedge i_txc);
    #2;
    i_reset_n = 1'b0;
    #1;
    checks++; if (o_gb_data !== 32'h0) begin errors++; $display("FAIL async_data: got %h expected 00000000", o_gb_data); end
    checks++; if (o_gb_seq !== 6'd0) begin errors++; $display("FAIL async_seq: got %0d expected 0", o_gb_seq); end
    checks++; if (o_tx_pause !== 1'b0) begin errors++; $display("FAIL async_pause: got %b expected 0", o_tx_pause); end
    tick();
    i_enable  = 1'b0;
    i_reset_n = 1'b1;
    tick();
  endtask

  task automatic test_cadence;
    int req_cnt;
    req_cnt = 0;
    flush();
    for (int c = 0; c < 99; c++) begin
      i_enable    = 1'b1;
      i_txd       = {$urandom, $urandom};
      i_tx_header = 2'b01;
      #1;
      if (o_block_req === 1'b1) req_cnt++;
      checks++; if (o_tx_pause !== ((c % 33) == 32)) begin errors++; $display("FAIL cadence_pause c=%0d: got %b expected %b", c, o_tx_pause, ((c % 33) == 32)); end
      checks++; if (o_gb_seq !== 6'(c % 33)) begin errors++; $display("FAIL cadence_seq c=%0d: got %0d expected %0d", c, o_gb_seq, c % 33); end
      tick();
    end
    checks++; if (req_cnt != 48) begin errors++; $display("FAIL cadence_req_count: got %0d expected 48", req_cnt); end
    flush();
  endtask

  task automatic test_bit_order;
    flush();
    i_enable    = 1'b1;
    i_tx_header = 2'b10;
    i_txd       = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    checks++; if (o_gb_data !== 32'h0) begin errors++; $display("FAIL bitorder_idle: got %h expected 00000000", o_gb_data); end
    checks++; if (o_block_req !== 1'b1) begin errors++; $display("FAIL bitorder_req: got %b expected 1", o_block_req); end
    tick();
    i_txd       = '0;
    i_tx_header = 2'b00;
    #1;
    checks++; if (o_gb_data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL bitorder_word0: got %h expected fffffffe", o_gb_data); end
    tick();
    #1;
    checks++; if (o_gb_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bitorder_word1: got %h expected ffffffff", o_gb_data); end
    flush();
  endtask

  task automatic test_period;
    logic [65:0]   blks [16];
    logic [1055:0] exp_bits;
    for (int i = 0; i < 16; i++) begin
      blks[i] = {$urandom, $urandom, 2'($urandom_range(0, 3))};
      exp_bits[66*i +: 66] = blks[i];
    end
    flush();
    for (int c = 0; c < 34; c++) begin
      i_enable = 1'b1;
      if (c < 32 && (c % 2) == 0) {i_txd, i_tx_header} = blks[c/2];
      else                        {i_txd, i_tx_header} = {$urandom, $urandom, 2'b11};
      #1;
      if (c >= 1) begin
        checks++; if (o_gb_data !== exp_bits[32*(c-1) +: 32]) begin errors++; $display("FAIL period_word%0d: got %h expected %h", c - 1, o_gb_data, exp_bits[32*(c-1) +: 32]); end
      end
`ifdef TX_GEARBOX_CHECK_EN
      checks++; if (o_gb_err !== 1'b0) begin errors++; $display("FAIL period_err c=%0d: got %b expected 0", c, o_gb_err); end
`endif
      tick();
    end
    flush();
  endtask

  task automatic test_reset_mid;
    flush();
    for (int c = 0; c < 17; c++) begin
      i_enable    = 1'b1;
      i_txd       = '1;
      i_tx_header = 2'b11;
      tick();
    end
    #1;
    checks++; if (o_gb_seq !== 6'd17) begin errors++; $display("FAIL rstmid_pre_seq: got %0d expected 17", o_gb_seq); end
    i_reset_n = 1'b0;
    #1;
    checks++; if (o_gb_seq !== 6'd0) begin errors++; $display("FAIL rstmid_seq: got %0d expected 0", o_gb_seq); end
    checks++; if (o_gb_data !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %h expected 00000000", o_gb_data); end
    tick();
    i_reset_n   = 1'b1;
    i_txd       = 64'h0;
    i_tx_header = 2'b01;
    #1;
    checks++; if (o_block_req !== 1'b1) begin errors++; $display("FAIL rstmid_req: got %b expected 1", o_block_req); end
    tick();
    i_txd       = '1;
    i_tx_header = 2'b11;
    #1;
    checks++; if (o_gb_data !== 32'h0000_0001) begin errors++; $display("FAIL rstmid_word0: got %h expected 00000001", o_gb_data); end
    checks++; if (o_gb_seq !== 6'd1) begin errors++; $display("FAIL rstmid_seq1: got %0d expected 1", o_gb_seq); end
    tick();
    #1;
    checks++; if (o_gb_data !== 32'h0) begin errors++; $display("FAIL rstmid_word1: got %h expected 00000000", o_gb_data); end
    flush();
  endtask

  task automatic test_enable_drop;
    flush();
    for (int c = 0; c < 9; c++) begin
      i_enable    = 1'b1;
      i_txd       = {$urandom, $urandom};
      i_tx_header = 2'b10;
      tick();
    end
    i_enable = 1'b0;
    #1;
    checks++; if (o_gb_seq !== 6'd9) begin errors++; $display("FAIL endrop_pre_seq: got %0d expected 9", o_gb_seq); end
    checks++; if (o_block_req !== 1'b0) begin errors++; $display("FAIL endrop_req_off: got %b expected 0", o_block_req); end
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (o_gb_data !== 32'h0) begin errors++; $display("FAIL endrop_data k=%0d: got %h expected 00000000", k, o_gb_data); end
      checks++; if (o_gb_seq !== 6'd0) begin errors++; $display("FAIL endrop_seq k=%0d: got %0d expected 0", k, o_gb_seq); end
      checks++; if (o_tx_pause !== 1'b0) begin errors++; $display("FAIL endrop_pause k=%0d: got %b expected 0", k, o_tx_pause); end
`ifdef TX_GEARBOX_CHECK_EN
      checks++; if (o_gb_err !== 1'b0) begin errors++; $display("FAIL endrop_err k=%0d: got %b expected 0", k, o_gb_err); end
`endif
      if (k < 3) tick();
    end
    i_enable    = 1'b1;
    i_txd       = 64'hA5A5_A5A5_A5A5_A5A5;
    i_tx_header = 2'b01;
    #1;
    checks++; if (o_block_req !== 1'b1) begin errors++; $display("FAIL endrop_req_on: got %b expected 1", o_block_req); end
    tick();
    i_txd = '0;
    #1;
    checks++; if (o_gb_data !== 32'h9696_9695) begin errors++; $display("FAIL endrop_word0: got %h expected 96969695", o_gb_data); end
    checks++; if (o_gb_seq !== 6'd1) begin errors++; $display("FAIL endrop_seq1: got %0d expected 1", o_gb_seq); end
`ifdef TX_GEARBOX_CHECK_EN
    checks++; if (o_gb_err !== 1'b0) begin errors++; $display("FAIL endrop_err_after: got %b expected 0", o_gb_err); end
`endif
    flush();
  endtask

  initial begin
    i_reset_n   = 1'b0;
    i_enable    = 1'b0;
    i_txd       = '0;
    i_tx_header = '0;
    test_reset();
    test_cadence();
    test_bit_order();
    test_period();
    test_reset_mid();
    test_enable_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
